// File: rtl/pulse_frame_packer_if.sv
// Bundle of the packer's sample input, byte output stream and status.
// The producer/consumer side (trigger stage + UART) uses master; the packer uses slave.
interface pulse_frame_packer_if;
  localparam int unsigned PULSE_W = 14;
  localparam int unsigned BYTE_W  = 8;

  logic               sample_valid;
  logic               trigger_in;
  logic [PULSE_W-1:0] pulse_in;
  logic [BYTE_W-1:0]  tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic               busy;
  logic [BYTE_W-1:0]  dropped_count;

  modport master (
    output sample_valid, trigger_in, pulse_in, tx_ready,
    input  tx_data, tx_valid, busy, dropped_count
  );

  modport slave (
    input  sample_valid, trigger_in, pulse_in, tx_ready,
    output tx_data, tx_valid, busy, dropped_count
  );
endinterface

// File: rtl/pulse_frame_packer.sv
// Captures a WINDOW-sample pulse on a trigger rising edge, tracks its peak and streams
// it as an A5 .. 5A byte frame; re-triggers during send/holdoff are counted as drops.
module pulse_frame_packer #(
  parameter int unsigned WINDOW  = 32,
  parameter int unsigned HOLDOFF = 16
) (
  input logic                 clk,
  input logic                 reset,
  pulse_frame_packer_if.slave bus
);
  localparam int unsigned PULSE_W    = 14;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned IDX_W      = $clog2(WINDOW + 1);
  localparam int unsigned ADDR_W     = $clog2(WINDOW);
  localparam int unsigned NBYTES     = 4 + 2 * WINDOW;
  localparam int unsigned BYTE_IDX_W = $clog2(NBYTES);
  localparam int unsigned HOLD_W     = 8;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_SEND, S_HOLDOFF} state_t;

  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(NBYTES - 1);

  state_t              state, state_n;
  logic                trig_prev, trig_prev_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic [PULSE_W-1:0]  peak, peak_n;
  logic [BYTE_IDX_W-1:0] byte_idx, byte_idx_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_n;
  logic                tx_valid_q, tx_valid_n;
  logic                busy_q, busy_n;
  logic [BYTE_W-1:0]   dropped_q, dropped_n;

  logic [PULSE_W-1:0]  mem [WINDOW];
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [BYTE_IDX_W-1:0] body_off;
  logic [ADDR_W-1:0]   rd_addr;
  logic [PULSE_W-1:0]  rd_sample;
  logic [BYTE_W-1:0]   cur_byte;
  logic                rise;

  assign bus.tx_data       = tx_data_q;
  assign bus.tx_valid      = tx_valid_q;
  assign bus.busy          = busy_q;
  assign bus.dropped_count = dropped_q;

  assign rise = bus.sample_valid && bus.trigger_in && !trig_prev;

  // Body bytes start at frame offset 3; each sample yields a high byte then a low byte.
  assign body_off  = byte_idx - BYTE_IDX_W'(3);
  assign rd_addr   = ADDR_W'(body_off >> 1);
  assign rd_sample = mem[rd_addr];

  always_comb begin
    cur_byte = 8'h5A;
    if (byte_idx == '0)                       cur_byte = 8'hA5;
    else if (byte_idx == BYTE_IDX_W'(1))      cur_byte = {2'b00, peak[13:8]};
    else if (byte_idx == BYTE_IDX_W'(2))      cur_byte = peak[7:0];
    else if (byte_idx != LAST_BYTE)
      cur_byte = body_off[0] ? rd_sample[7:0] : {2'b00, rd_sample[13:8]};
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    peak_n      = peak;
    byte_idx_n  = byte_idx;
    hold_cnt_n  = hold_cnt;
    tx_data_n   = tx_data_q;
    tx_valid_n  = tx_valid_q;
    dropped_n   = dropped_q;
    wr_en       = 1'b0;
    wr_addr     = ADDR_W'(idx);
    trig_prev_n = bus.sample_valid ? bus.trigger_in : trig_prev;

    case (state)
      S_IDLE: begin
        if (rise) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          peak_n  = bus.pulse_in;
          idx_n   = IDX_W'(1);
          state_n = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (bus.sample_valid) begin
          wr_en = 1'b1;
          if (bus.pulse_in > peak) peak_n = bus.pulse_in;
          idx_n = idx + IDX_W'(1);
          if (idx == IDX_W'(WINDOW - 1)) begin
            state_n    = S_SEND;
            byte_idx_n = '0;
          end
        end
      end
      S_SEND: begin
        if (rise && dropped_q != 8'hFF) dropped_n = dropped_q + 8'd1;
        // Present a byte after every idle cycle; hold it until accepted.
        if (!tx_valid_q) begin
          tx_valid_n = 1'b1;
          tx_data_n  = cur_byte;
        end else if (bus.tx_ready) begin
          tx_valid_n = 1'b0;
          if (byte_idx == LAST_BYTE) begin
            state_n    = (HOLDOFF == 0) ? S_IDLE : S_HOLDOFF;
            hold_cnt_n = '0;
          end else begin
            byte_idx_n = byte_idx + BYTE_IDX_W'(1);
          end
        end
      end
      S_HOLDOFF: begin
        if (rise && dropped_q != 8'hFF) dropped_n = dropped_q + 8'd1;
        if (bus.sample_valid) begin
          if (9'(hold_cnt) + 9'd1 == 9'(HOLDOFF)) state_n = S_IDLE;
          else hold_cnt_n = hold_cnt + HOLD_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      trig_prev  <= 1'b0;
      idx        <= '0;
      peak       <= '0;
      byte_idx   <= '0;
      hold_cnt   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      dropped_q  <= '0;
    end else begin
      state      <= state_n;
      trig_prev  <= trig_prev_n;
      idx        <= idx_n;
      peak       <= peak_n;
      byte_idx   <= byte_idx_n;
      hold_cnt   <= hold_cnt_n;
      tx_data_q  <= tx_data_n;
      tx_valid_q <= tx_valid_n;
      busy_q     <= busy_n;
      dropped_q  <= dropped_n;
    end
  end

  // Sample buffer carries no reset; it is always rewritten before being read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= bus.pulse_in;
  end
endmodule
